// File: rtl/muldiv_unit.sv
// Purpose: iterative 32x32 multiply (shift-add) and divide (restoring) unit with HI/LO result registers.
// Latency: md_start accepted at edge N gives done=1 in the cycle after edge N+32 (33 cycles), for every op.
// Backpressure: busy=1 for the 32 RUN cycles; md_start, mthi and mtlo are ignored while busy is high.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Architectural and control state
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Latched operation: op class, raw dividend, operand signs
    logic        is_div_q, is_div_d;
    logic [31:0] srca_q, srca_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;

    // Working registers. Multiply: whi:wlo is the running product/multiplier,
    // mcand is |multiplicand|. Divide: whi is the partial remainder, wlo holds
    // the dividend bits being shifted out and quotient bits shifted in,
    // mcand is |divisor|.
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] whi_q, whi_d;
    logic [31:0] wlo_q, wlo_d;

    // Iteration datapath
    logic        start_acc;
    logic        op_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] m_sum;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [32:0] d_shift;
    logic        d_ge;
    logic [31:0] d_diff;
    logic [31:0] d_hi;
    logic [31:0] d_lo;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        res_neg;

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // One shift-add / shift-subtract step on the working registers, plus sign fix-up of the final step
    always_comb begin
        start_acc = md_start & ~busy_q;
        op_signed = ~md_op[0];
        abs_a     = (op_signed && srcA[31]) ? (~srcA + 32'd1) : srcA;
        abs_b     = (op_signed && srcB[31]) ? (~srcB + 32'd1) : srcB;

        // Multiply: add multiplicand when the current multiplier bit is set, then shift right
        m_sum = {1'b0, whi_q} + (wlo_q[0] ? {1'b0, mcand_q} : 33'd0);
        m_hi  = m_sum[32:1];
        m_lo  = {m_sum[0], wlo_q[31:1]};

        // Divide: shift next dividend bit into the remainder, subtract the divisor if it fits.
        // When it fits, the difference is below the divisor so 32 bits of it are exact.
        d_shift = {whi_q, wlo_q[31]};
        d_ge    = (d_shift >= {1'b0, mcand_q});
        d_diff  = d_shift[31:0] - mcand_q;
        d_hi    = d_ge ? d_diff : d_shift[31:0];
        d_lo    = {wlo_q[30:0], d_ge};

        // Magnitude results are negated when operand signs differ; remainder follows the dividend
        res_neg = neg_a_q ^ neg_b_q;
        prod    = res_neg ? (~{m_hi, m_lo} + 64'd1) : {m_hi, m_lo};
        quot    = res_neg ? (~d_lo + 32'd1) : d_lo;
        rem     = neg_a_q ? (~d_hi + 32'd1) : d_hi;
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer, operand latch and HI/LO writes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        srca_d   = srca_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        mcand_d  = mcand_q;
        whi_d    = whi_q;
        wlo_d    = wlo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    // Start wins over mthi/mtlo in the same cycle
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    cnt_d    = 5'd0;
                    is_div_d = md_op[1];
                    srca_d   = srcA;
                    neg_a_d  = op_signed & srcA[31];
                    neg_b_d  = op_signed & srcB[31];
                    whi_d    = 32'd0;
                    mcand_d  = md_op[1] ? abs_b : abs_a;
                    wlo_d    = md_op[1] ? abs_a : abs_b;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    if (mthi) hi_d = srcA;
                    if (mtlo) lo_d = srcA;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 5'd1;
                whi_d = is_div_q ? d_hi : m_hi;
                wlo_d = is_div_q ? d_lo : m_lo;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (mcand_q == 32'd0) begin
                        // Divide by zero: all-ones quotient, dividend passed through as remainder
                        hi_d  = srca_q;
                        lo_d  = 32'hFFFF_FFFF;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            is_div_q <= 1'b0;
            srca_q   <= 32'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mcand_q  <= 32'd0;
            whi_q    <= 32'd0;
            wlo_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            srca_q   <= srca_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            mcand_q  <= mcand_d;
            whi_q    <= whi_d;
            wlo_q    <= wlo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose: self-checking bench for muldiv_unit (vector table, corner sequences, random ops vs model).
// Latency: expects done exactly 33 cycles after an accepted md_start, busy for 32 of them.
// Backpressure: checks that md_start/mthi/mtlo are ignored while busy and that start wins over mthi/mtlo.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        md_start;
    logic [1:0]  md_op;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    int   n_pass;
    int   n_total;

    muldiv_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .srcA        (srcA),
        .srcB        (srcB),
        .md_start    (md_start),
        .md_op       (md_op),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add_vec(input string n, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.ehi = ehi; v.elo = elo; v.edbz = edbz;
        vq.push_back(v);
    endtask

    // Reference results from native wide arithmetic
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa, sbv, sr;
        logic [63:0] ua, ub, ur;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        e.name = "rand";
        e.dbz  = 1'b0;
        case (op)
            OP_MULT:  begin sr = sa * sbv; e.hi = sr[63:32]; e.lo = sr[31:0]; end
            OP_MULTU: begin ur = ua * ub;  e.hi = ur[63:32]; e.lo = ur[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    sr = sa / sbv; e.lo = sr[31:0];
                    sr = sa % sbv; e.hi = sr[31:0];
                end else begin
                    ur = ua / ub; e.lo = ur[31:0];
                    ur = ua % ub; e.hi = ur[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Caller is at a falling edge; drives a one-cycle start and optionally queues the expected result
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input exp_t e, input bit push);
        md_start = 1'b1; md_op = op; srcA = a; srcB = b;
        if (push) sb.push_back(e);
        @(negedge clk);
        md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    endtask

    // lat0 = number of cycles since the start edge at the current falling edge (1 right after start_op)
    task automatic wait_done(input int lat0);
        int   lat;
        int   bc;
        exp_t e;
        lat = lat0;
        bc  = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard: got empty queue, expected a pending result");
            return;
        end
        e = sb.pop_front();
        check({e.name, "_latency"}, 64'(lat), 64'd33);
        check({e.name, "_busy_cycles"}, 64'(bc), 64'(33 - lat0));
        check({e.name, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
        check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
        check({e.name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
        @(negedge clk);
        check({e.name, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({e.name, "_dbz_after"}, {63'd0, div_by_zero}, 64'd0);
    endtask

    function automatic exp_t mk(input string n, input logic [31:0] h, input logic [31:0] l, input logic d);
        exp_t e;
        e.name = n; e.hi = h; e.lo = l; e.dbz = d;
        return e;
    endfunction

    initial begin
        exp_t e;
        int   seen;
        logic [31:0] last_hi;
        logic [31:0] last_lo;

        n_pass = 0; n_total = 0;
        md_start = 1'b0; md_op = 2'b00; srcA = 32'd0; srcB = 32'd0; mthi = 1'b0; mtlo = 1'b0;

        add_vec("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        add_vec("mult_m3x7",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        add_vec("div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        add_vec("divu_100d7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        add_vec("divu_by0",    OP_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        add_vec("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        add_vec("div_7dm2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        add_vec("div_m7dm2",   OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0);
        add_vec("div_by0_s",   OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        add_vec("mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        add_vec("mult_m1m1",   OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        add_vec("multu_2p32",  OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
        add_vec("divu_5d7",    OP_DIVU,  32'd5,         32'd7,         32'd5,         32'd0,         1'b0);

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        check("reset_hi",   {32'd0, hi}, 64'd0);
        check("reset_lo",   {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz",  {63'd0, div_by_zero}, 64'd0);

        // Table: the first start is presented on the very first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            start_op(vq[i].op, vq[i].a, vq[i].b, mk(vq[i].name, vq[i].ehi, vq[i].elo, vq[i].edbz), 1'b1);
            wait_done(1);
        end
        last_hi = vq[vq.size()-1].ehi;
        last_lo = vq[vq.size()-1].elo;

        // Start and mthi pulsed mid-operation are ignored; HI/LO hold during RUN
        start_op(OP_MULTU, 32'd3, 32'd5, mk("multu_3x5", 32'd0, 32'd15, 1'b0), 1'b1);
        repeat (8) @(negedge clk);
        md_start = 1'b1; mthi = 1'b1; md_op = OP_DIVU; srcA = 32'hDEAD_BEEF; srcB = 32'd0;
        @(negedge clk);
        md_start = 1'b0; mthi = 1'b0;
        check("run_hi_hold", {32'd0, hi}, {32'd0, last_hi});
        check("run_lo_hold", {32'd0, lo}, {32'd0, last_lo});
        wait_done(10);

        mthi = 1'b1; srcA = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'h0000_0000_DEAD_BEEF);
        check("mthi_lo", {32'd0, lo}, 64'd15);
        mthi = 1'b1; mtlo = 1'b1; srcA = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);
        check("mthilo_lo", {32'd0, lo}, 64'h0000_0000_CAFE_F00D);

        // Start wins over mthi/mtlo in the same cycle
        mthi = 1'b1; mtlo = 1'b1;
        start_op(OP_MULTU, 32'd3, 32'd5, mk("start_wins", 32'd0, 32'd15, 1'b0), 1'b1);
        check("start_wins_hi", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);
        check("start_wins_lo", {32'd0, lo}, 64'h0000_0000_CAFE_F00D);
        wait_done(1);

        // Reset mid-divide aborts with no done afterwards
        start_op(OP_DIVU, 32'd1000, 32'd3, mk("aborted", 32'd0, 32'd0, 1'b0), 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_hi",   {32'd0, hi}, 64'd0);
        check("abort_lo",   {32'd0, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        start_op(OP_MULTU, 32'd2, 32'd2, mk("multu_2x2", 32'd0, 32'd4, 1'b0), 1'b1);
        wait_done(1);

        // Random operations against the reference model
        for (int k = 0; k < 8; k++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (k == 5) ? 32'd0 : $urandom;
            if (k == 2) b = 32'($urandom_range(1, 9));
            e = model(op, a, b);
            start_op(op, a, b, e, 1'b1);
            wait_done(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-003 SHALL have port srcA, input, 32 bits: first operand, i.e. the multiplicand or dividend, taken from the same operand bus that feeds the ALU.
REQ-004 SHALL have port srcB, input, 32 bits: second operand, i.e. the multiplier or divisor.
REQ-005 SHALL have port md_start, input, 1 bit: request to start an operation.
REQ-006 SHALL have port md_op, input, 2 bits: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-007 SHALL have ports mthi and mtlo, input, 1 bit each: write srcA directly into HI or LO.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse meaning the result is valid.
REQ-010 SHALL have port div_by_zero, output, 1 bit: valid only while done=1.
REQ-011 SHALL have ports hi and lo, output, 32 bits each: architectural HI and LO registers.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE.
REQ-013 SHALL accept md_start only when busy=0, i.e. in IDLE or DONE; when accepted, it latches srcA, srcB and md_op, clears the 5-bit iteration counter and enters RUN.
REQ-014 SHALL ignore md_start while busy=1; operands, op, counter, hi and lo stay unchanged.
REQ-015 SHALL hold busy=1 for exactly 32 cycles in RUN, performing one iteration per clock edge.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
REQ-016 SHALL, on the 32nd RUN edge, write the result to hi/lo and enter DONE; DONE lasts one cycle with done=1 and busy=0, then returns to IDLE unless a new md_start is accepted.
REQ-017 SHALL have a latency of 33 cycles: start sampled at edge N produces done=1 in the cycle after edge N+32.
REQ-018 SHALL produce the full 64-bit product for MULT and MULTU as {hi,lo}.
  - Signed operation works on magnitudes; the result is negated when the operand signs differ.
REQ-019 SHALL produce lo=quotient and hi=remainder for DIV and DIVU.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
REQ-020 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0x00000000, div_by_zero=0.
REQ-021 SHALL, when the divisor is 0 (signed or unsigned), still take the full 33-cycle latency and produce:
  - lo=0xFFFFFFFF
  - hi=latched dividend
  - div_by_zero=1 during done.
REQ-022 SHALL drive div_by_zero=0 whenever done=0 or the operation is a multiply.
REQ-023 SHALL, with busy=0, load srcA into hi on mthi=1 and into lo on mtlo=1 at the next edge; both may be written in the same cycle.
REQ-024 SHALL ignore mthi and mtlo while busy=1, and also when md_start is accepted in the same cycle (start wins).
REQ-025 SHALL hold hi and lo unchanged at every other time, including during RUN; intermediate values are kept in internal registers only.
REQ-026 SHALL generate done from registered state, not as a combinational function of its inputs.

Reset
REQ-027 SHALL, while rst_n=0, immediately force:
  - state to IDLE
  - busy=0, done=0, div_by_zero=0
  - hi=0x00000000, lo=0x00000000
  - iteration counter to 0.
REQ-028 SHALL abort an operation in progress when rst_n is asserted mid-operation; no done pulse follows reset release.
REQ-029 SHALL accept md_start on the first clock edge after rst_n is deasserted.

Verification
REQ-030 SHALL be verified with MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles; done high for 1 cycle, 33 cycles after start.
REQ-031 SHALL be verified with MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 SHALL be verified with DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIVU 100/7 -> lo=14, hi=2.
REQ-033 SHALL be verified with DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1 for the done cycle only.
REQ-034 SHALL be verified by pulsing md_start and mthi=1 with srcA=0xDEADBEEF at cycle 10 of a MULTU 3x5 -> both ignored; result hi=0, lo=15; then mthi with busy=0 -> hi=0xDEADBEEF.
REQ-035 SHALL be verified by asserting rst_n=0 at cycle 20 of a DIVU -> hi=lo=0, busy=0 immediately; no done pulse after release; a new MULTU 2x2 then yields lo=4.
